count_event_detector: RTL

- Downstream consumer of the 4-bit loadable up-counter's `count` output.
- Samples the count every clock and produces registered one-cycle pulses on two events:
  - wrap-around (count goes from max to 0);
  - compare-match (count arrives at a programmed value).
- Keeps a saturating tally of match events.
- Gives the rest of the design a timer/interval-event source without touching the counter itself.

---
 rtl/count_event_detector.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/count_event_detector.sv
// -----------------------------------------------------------------------------
// count_event_detector
//
// Watches the value of a free-running/loadable up-counter and turns it into
// interval events for the rest of the design:
//   * wrap_pulse  - one-cycle pulse when the count goes from all-ones to zero
//   * match_pulse - one-cycle pulse when the count arrives at cmp_val while
//                   armed. A value that is already present when arming starts,
//                   or a counter stalled on cmp_val, does not produce extra pulses.
//   * evt_count   - saturating tally of match pulses, with sticky evt_sat
//
// Ports:
//   clk         rising-edge clock, shared with the counter
//   rst         asynchronous active-low reset
//   cnt_in      counter value being monitored      [WIDTH-1:0]
//   cmp_val     compare value, static while arm=1  [WIDTH-1:0]
//   arm         level enable for match detection; 0 forces IDLE
//   clr         synchronous clear of evt_count / evt_sat
//   match_pulse registered one-cycle match pulse
//   wrap_pulse  registered one-cycle wrap pulse
//   evt_count   saturating match tally             [EVT_W-1:0]
//   evt_sat     sticky, set once evt_count reaches all-ones
//   busy        1 while the match FSM is ARMED or HOLD
//   state_dbg   current match FSM state (0=IDLE, 1=ARMED, 2=HOLD)
//
// All outputs are registered, so events appear one clock after the edge
// that sampled the triggering cnt_in.
// -----------------------------------------------------------------------------
module count_event_detector #(
  parameter int WIDTH = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             arm,
  input  logic             clr,
  output logic             match_pulse,
  output logic             wrap_pulse,
  output logic [EVT_W-1:0] evt_count,
  output logic             evt_sat,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};
  localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);

  state_t           state_q,       state_d;
  logic [WIDTH-1:0] prev_cnt_q,    prev_cnt_d;
  logic             prev_valid_q,  prev_valid_d;
  logic             match_pulse_q, match_pulse_d;
  logic             wrap_pulse_q,  wrap_pulse_d;
  logic [EVT_W-1:0] evt_count_q,   evt_count_d;
  logic             evt_sat_q,     evt_sat_d;
  logic             busy_q,        busy_d;

  logic hit;
  assign hit = (cnt_in == cmp_val);

  // ---------------------------------------------------------------------------
  // Next-state and output computation
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    match_pulse_d = 1'b0;
    prev_cnt_d    = cnt_in;
    prev_valid_d  = 1'b1;

    // Wrap only counts once a real previous sample exists, so the first
    // edge after reset can never fire.
    wrap_pulse_d = prev_valid_q && (prev_cnt_q == CNT_MAX) && (cnt_in == '0);

    // arm=0 overrides every transition.
    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          // A match already present when arming starts is not an arrival.
          state_d = hit ? S_HOLD : S_ARMED;
        end
      end
      S_ARMED: begin
        if (!arm) begin
          state_d = S_IDLE;
        end else if (hit) begin
          state_d       = S_HOLD;
          match_pulse_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (!arm) begin
          state_d = S_IDLE;
        end else if (!hit) begin
          state_d = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    // Tally: clr beats a simultaneous increment (the pulse itself still goes
    // out). The count holds at all-ones rather than wrapping.
    evt_count_d = evt_count_q;
    evt_sat_d   = evt_sat_q;
    if (clr) begin
      evt_count_d = '0;
      evt_sat_d   = 1'b0;
    end else if (match_pulse_d) begin
      if (evt_count_q != EVT_MAX) begin
        evt_count_d = evt_count_q + EVT_ONE;
      end
      if ((evt_count_q == EVT_MAX) || (evt_count_q + EVT_ONE == EVT_MAX)) begin
        evt_sat_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      prev_cnt_q    <= '0;
      prev_valid_q  <= 1'b0;
      match_pulse_q <= 1'b0;
      wrap_pulse_q  <= 1'b0;
      evt_count_q   <= '0;
      evt_sat_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_cnt_q    <= prev_cnt_d;
      prev_valid_q  <= prev_valid_d;
      match_pulse_q <= match_pulse_d;
      wrap_pulse_q  <= wrap_pulse_d;
      evt_count_q   <= evt_count_d;
      evt_sat_q     <= evt_sat_d;
      busy_q        <= busy_d;
    end
  end

  assign match_pulse = match_pulse_q;
  assign wrap_pulse  = wrap_pulse_q;
  assign evt_count   = evt_count_q;
  assign evt_sat     = evt_sat_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;

endmodule
